// File: rtl/par2ser_tx_pkg.sv
// par2ser_tx_pkg: line symbols shared with the deserializer and the transmitter state encoding
package par2ser_tx_pkg;
  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_IDLE = 8'h7C;
  typedef enum logic {TRAIN = 1'b0, ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/ser_shift_reg.sv
// ser_shift_reg: load/shift register with bit counter, flags symbol boundaries
module ser_shift_reg
  import par2ser_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sym,
  output logic             boundary,
  output logic             msb
);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0] bit_cnt;
  assign boundary = bit_cnt == BW'(WIDTH - 1);
  assign msb = sr[WIDTH-1];
  always_ff @(posedge clk)
    if (!reset) begin
      sr <= '0;
      bit_cnt <= BW'(WIDTH - 1);
    end else if (boundary) begin
      sr <= sym << 1;
      bit_cnt <= '0;
    end else begin
      sr <= sr << 1;
      bit_cnt <= bit_cnt + BW'(1);
    end
endmodule

// File: rtl/par2ser_tx.sv
// par2ser_tx: MSB-first serializer with comma training, idle/comma fill and data byte counting
module par2ser_tx
  import par2ser_tx_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] COMMA       = WIDTH'(K_COMMA),
  parameter logic [WIDTH-1:0] IDLE_SYM    = WIDTH'(K_IDLE),
  parameter int               TRAIN_COUNT = 4,
  parameter int               CNT_W       = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             idle_in,
  output logic             data_out,
  output logic             byte_sync,
  output logic             active,
  output logic [CNT_W-1:0] data_count
);
  localparam int TW = $clog2(TRAIN_COUNT + 1);
  state_t state;
  logic [TW-1:0] train_cnt;
  logic boundary, msb, live;
  logic [WIDTH-1:0] sym;
  // live also covers the last training boundary, so the first data symbol loads on that edge
  assign live = state == ACTIVE || train_cnt == TW'(TRAIN_COUNT);
  assign sym = !live ? COMMA : valid_in ? data_in : idle_in ? IDLE_SYM : COMMA;
  assign active = state == ACTIVE;
  ser_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk(clk_32f),
    .reset(reset),
    .sym(sym),
    .boundary(boundary),
    .msb(msb)
  );
  always_ff @(posedge clk_32f)
    if (!reset) begin
      state <= TRAIN;
      train_cnt <= '0;
      data_out <= 1'b0;
      byte_sync <= 1'b0;
      data_count <= '0;
    end else begin
      data_out <= boundary ? sym[WIDTH-1] : msb;
      byte_sync <= boundary;
      if (boundary) begin
        if (live) begin
          state <= ACTIVE;
          if (valid_in) data_count <= data_count + CNT_W'(1);
        end else train_cnt <= train_cnt + TW'(1);
      end
    end
endmodule

// File: tb/tb_par2ser_tx.sv
// tb_par2ser_tx: directed checks of training, symbol selection, mid-byte reset and counter wrap
module tb_par2ser_tx;
  logic clk_32f = 1'b0;
  logic reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic valid_in = 1'b0;
  logic idle_in = 1'b0;
  logic data_out, byte_sync, active, data_out4, byte_sync4, active4;
  logic [15:0] data_count;
  logic [3:0] data_count4;
  logic [15:0] ecnt = 16'd0;
  int total = 0;
  int bad = 0;

  always #5 clk_32f = ~clk_32f;

  par2ser_tx dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in), .idle_in(idle_in),
    .data_out(data_out), .byte_sync(byte_sync), .active(active), .data_count(data_count)
  );

  par2ser_tx #(.CNT_W(4)) dut4 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in), .idle_in(idle_in),
    .data_out(data_out4), .byte_sync(byte_sync4), .active(active4), .data_count(data_count4)
  );

  task automatic tick;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (4) tick();
    total += 4;
    if (data_out !== 1'b0) begin bad++; $display("FAIL reset_data_out got=%b exp=0", data_out); end
    if (byte_sync !== 1'b0) begin bad++; $display("FAIL reset_byte_sync got=%b exp=0", byte_sync); end
    if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
    if (data_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", data_count); end
  endtask

  task automatic test_training(input string tag);
    logic [7:0] c;
    c = 8'hBC;
    reset = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      total += 3;
      if (data_out !== c[7-(k%8)]) begin bad++; $display("FAIL %s_bit k=%0d got=%b exp=%b", tag, k, data_out, c[7-(k%8)]); end
      if (byte_sync !== (k % 8 == 0)) begin bad++; $display("FAIL %s_sync k=%0d got=%b exp=%b", tag, k, byte_sync, k % 8 == 0); end
      if (active !== 1'b0) begin bad++; $display("FAIL %s_active k=%0d got=%b exp=0", tag, k, active); end
    end
  endtask

  task automatic test_first_data;
    logic [7:0] d;
    d = 8'hA5;
    ecnt = 16'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total += 4;
      if (active !== 1'b1) begin bad++; $display("FAIL data_active i=%0d got=%b exp=1", i, active); end
      if (data_out !== d[7-i]) begin bad++; $display("FAIL data_bit i=%0d got=%b exp=%b", i, data_out, d[7-i]); end
      if (byte_sync !== (i == 0)) begin bad++; $display("FAIL data_sync i=%0d got=%b exp=%b", i, byte_sync, i == 0); end
      if (data_count !== ecnt) begin bad++; $display("FAIL data_count i=%0d got=%0d exp=%0d", i, data_count, ecnt); end
    end
  endtask

  task automatic test_idle_comma;
    logic [7:0] s;
    valid_in = 1'b0;
    for (int b = 0; b < 2; b++) begin
      idle_in = (b == 0);
      s = (b == 0) ? 8'h7C : 8'hBC;
      for (int i = 0; i < 8; i++) begin
        tick();
        total += 2;
        if (data_out !== s[7-i]) begin bad++; $display("FAIL fill_bit sym=%h i=%0d got=%b exp=%b", s, i, data_out, s[7-i]); end
        if (data_count !== ecnt) begin bad++; $display("FAIL fill_count sym=%h i=%0d got=%0d exp=%0d", s, i, data_count, ecnt); end
      end
    end
  endtask

  task automatic test_valid_wins;
    logic [7:0] d;
    d = 8'h3C;
    valid_in = 1'b1;
    idle_in = 1'b1;
    data_in = d;
    ecnt = ecnt + 16'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) data_in = 8'hC3;
      if (i == 4) data_in = 8'h00;
      total += 2;
      if (data_out !== d[7-i]) begin bad++; $display("FAIL both_bit i=%0d got=%b exp=%b", i, data_out, d[7-i]); end
      if (data_count !== ecnt) begin bad++; $display("FAIL both_count i=%0d got=%0d exp=%0d", i, data_count, ecnt); end
    end
    idle_in = 1'b0;
  endtask

  task automatic test_mid_reset;
    logic [7:0] d;
    d = 8'h5A;
    data_in = d;
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (data_out !== d[7-i]) begin bad++; $display("FAIL pre_reset_bit i=%0d got=%b exp=%b", i, data_out, d[7-i]); end
    end
    reset = 1'b0;
    tick();
    ecnt = 16'd0;
    total += 4;
    if (data_out !== 1'b0) begin bad++; $display("FAIL mid_reset_data_out got=%b exp=0", data_out); end
    if (active !== 1'b0) begin bad++; $display("FAIL mid_reset_active got=%b exp=0", active); end
    if (byte_sync !== 1'b0) begin bad++; $display("FAIL mid_reset_sync got=%b exp=0", byte_sync); end
    if (data_count !== 16'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", data_count); end
    test_training("retrain");
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    for (int b = 0; b < 17; b++) begin
      d = 8'(b * 37 + 1);
      data_in = d;
      valid_in = 1'b1;
      ecnt = ecnt + 16'd1;
      for (int i = 0; i < 8; i++) begin
        tick();
        total += 5;
        if (data_out !== d[7-i]) begin bad++; $display("FAIL wrap_bit b=%0d i=%0d got=%b exp=%b", b, i, data_out, d[7-i]); end
        if (data_out4 !== d[7-i]) begin bad++; $display("FAIL wrap_bit4 b=%0d i=%0d got=%b exp=%b", b, i, data_out4, d[7-i]); end
        if (byte_sync4 !== (i == 0)) begin bad++; $display("FAIL wrap_sync4 b=%0d i=%0d got=%b exp=%b", b, i, byte_sync4, i == 0); end
        if (data_count !== ecnt) begin bad++; $display("FAIL wrap_count b=%0d got=%0d exp=%0d", b, data_count, ecnt); end
        if (data_count4 !== ecnt[3:0] || active4 !== 1'b1) begin
          bad++;
          $display("FAIL wrap_count4 b=%0d got=%0d/%b exp=%0d/1", b, data_count4, active4, ecnt[3:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    valid_in = 1'b1;
    data_in = 8'hA5;
    test_training("train");
    test_first_data();
    test_idle_comma();
    test_valid_wins();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
